// File: rtl/preg_free_list_if.sv
// Rename/commit-facing bundle of the physical register free list.
// The rename/commit side uses the master modport; the free list uses slave.
interface preg_free_list_if #(
  parameter int unsigned PREG_NUM     = 64,
  parameter int unsigned AREG_NUM     = 32,
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned COMMIT_WIDTH = 2
);
  localparam int unsigned PW    = $clog2(PREG_NUM);
  localparam int unsigned DEPTH = PREG_NUM - AREG_NUM;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic [FETCH_WIDTH-1:0]     alloc_req;
  logic                       alloc_en;
  logic                       alloc_ready;
  logic [FETCH_WIDTH*PW-1:0]  alloc_id;
  logic [COMMIT_WIDTH-1:0]    free_valid;
  logic [COMMIT_WIDTH*PW-1:0] free_id;
  logic [COMMIT_WIDTH-1:0]    commit_alloc;
  logic                       flush;
  logic [CW-1:0]              free_count;
  logic                       overflow;

  modport master (
    output alloc_req, alloc_en, free_valid, free_id, commit_alloc, flush,
    input  alloc_ready, alloc_id, free_count, overflow
  );

  modport slave (
    input  alloc_req, alloc_en, free_valid, free_id, commit_alloc, flush,
    output alloc_ready, alloc_id, free_count, overflow
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical register ids: rename pops from head, commit pushes at tail,
// and a committed head (chead) lets a flush return all speculative allocations in one cycle.
module preg_free_list #(
  parameter int unsigned PREG_NUM     = 64,
  parameter int unsigned AREG_NUM     = 32,
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input logic              clk,
  input logic              resetn,
  preg_free_list_if.slave  fl
);
  localparam int unsigned PW    = $clog2(PREG_NUM);
  localparam int unsigned DEPTH = PREG_NUM - AREG_NUM;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned PTRW  = IW + 1;

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] head, chead, tail;
  logic            overflow_q;

  logic [PTRW-1:0] count, n_a, n_a_eff, n_f, n_c;
  logic [PTRW-1:0] head_next, chead_next, tail_next;
  logic [IW-1:0]   rd_idx [FETCH_WIDTH];
  logic [IW-1:0]   wr_idx [COMMIT_WIDTH];
  logic [FETCH_WIDTH*PW-1:0] alloc_id_w;
  logic            ready, do_alloc, ovf_now;

  // Readiness depends only on registered pointers, never on alloc_req.
  assign count = tail - head;
  assign ready = (count >= PTRW'(FETCH_WIDTH));

  always_comb begin
    n_a = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      rd_idx[i] = IW'(head + n_a);
      if (fl.alloc_req[i]) n_a = n_a + PTRW'(1);
    end
    alloc_id_w = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      alloc_id_w[i*PW +: PW] = mem[rd_idx[i]];
    end
  end

  // Valid frees are compacted into consecutive slots starting at tail.
  always_comb begin
    n_f = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      wr_idx[j] = IW'(tail + n_f);
      if (fl.free_valid[j]) n_f = n_f + PTRW'(1);
    end
    n_c = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      if (fl.commit_alloc[j]) n_c = n_c + PTRW'(1);
    end
  end

  always_comb begin
    do_alloc   = fl.alloc_en & ready & ~fl.flush;
    n_a_eff    = do_alloc ? n_a : '0;
    chead_next = chead + n_c;
    tail_next  = tail + n_f;
    head_next  = fl.flush ? chead_next : head + n_a_eff;
    ovf_now    = ((tail_next - head_next) > PTRW'(DEPTH)) || (n_c > (tail_next - chead));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= PW'(AREG_NUM + k);
      head       <= '0;
      chead      <= '0;
      tail       <= PTRW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
        if (fl.free_valid[j]) mem[wr_idx[j]] <= fl.free_id[j*PW +: PW];
      end
      head       <= head_next;
      chead      <= chead_next;
      tail       <= tail_next;
      overflow_q <= overflow_q | ovf_now;
    end
  end

  assign fl.alloc_ready = ready;
  assign fl.alloc_id    = alloc_id_w;
  assign fl.free_count  = count;
  assign fl.overflow    = overflow_q;
endmodule
